// File: rtl/code_4a_pkg.sv
// Shared widths and vector types for the code_4a one-hot select decoder.
package code_4a_pkg;

  localparam int SEL_W = 2;
  localparam int OUT_W = 2 ** SEL_W;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OUT_W-1:0] onehot_t;

endpackage

// File: rtl/code_4a_dec.sv
// Pure combinational 2-to-4 decoder with enable; every (en, a) pair yields a defined value.
module code_4a_dec
  import code_4a_pkg::*;
(
  input  logic    en,
  input  sel_t    a,
  output onehot_t d
);

  // Unknown select values fall into the default arm and decode to all zeros.
  always_comb begin
    d = '0;
    if (en) begin
      case (a)
        2'b00:   d = 4'b0001;
        2'b01:   d = 4'b0010;
        2'b10:   d = 4'b0100;
        2'b11:   d = 4'b1000;
        default: d = '0;
      endcase
    end
  end

endmodule

// File: rtl/code_4a.sv
// Registered one-hot strobe generator: decodes a 2-bit index into four exclusive enables.
module code_4a
  import code_4a_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] a,
  output logic [OUT_W-1:0] y,
  output logic             y_valid
);

  onehot_t d;

  code_4a_dec u_dec (
    .en (en),
    .a  (a),
    .d  (d)
  );

  // y_valid is en delayed alongside y, so it can never disagree with the decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y       <= d;
      y_valid <= en;
    end
  end

endmodule

// File: tb/tb_code_4a.sv
// Scoreboard bench for code_4a: expected decodes are queued at drive time and popped one cycle later.
module tb_code_4a;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] a;
  logic [3:0] y;
  logic       y_valid;

  typedef struct packed {
    logic [3:0] y;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  int   compared;
  int   mismatched;

  code_4a dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .a       (a),
    .y       (y),
    .y_valid (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model(input logic e, input logic [1:0] s);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      r[i] = e && (s == i[1:0]);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    if (obs !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Drive on the falling edge and queue what the next rising edge must produce.
  task automatic applyStimulus(input logic e, input logic [1:0] s);
    exp_t ex;
    @(negedge clk);
    en = e;
    a  = s;
    ex.y     = model(e, s);
    ex.valid = e;
    exp_q.push_back(ex);
  endtask

  task automatic sampleOutput(input string tag);
    exp_t ex;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      ex = exp_q.pop_front();
      checkOutput({tag, "_y"}, {28'd0, y}, {28'd0, ex.y});
      checkOutput({tag, "_valid"}, {31'd0, y_valid}, {31'd0, ex.valid});
      checkOutput({tag, "_onehot"}, $countones(y), {31'd0, y_valid});
    end
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    en  = 1'b1;
    a   = 2'b10;

    // Reset held across edges keeps outputs clear.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("por_y", {28'd0, y}, 32'd0);
    checkOutput("por_valid", {31'd0, y_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load a live value, then assert reset mid-cycle and check it clears immediately.
    applyStimulus(1'b1, 2'b10);
    sampleOutput("pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_y", {28'd0, y}, 32'd0);
    checkOutput("async_rst_valid", {31'd0, y_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_y", {28'd0, y}, 32'd0);
    checkOutput("rst_hold_valid", {31'd0, y_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'(i));
      sampleOutput("dis_sweep");
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i));
      sampleOutput("en_sweep");
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(i[2], i[1:0]);
      sampleOutput("full_sweep");
    end

    // Single-cycle enable drop.
    applyStimulus(1'b1, 2'b11);
    sampleOutput("glitch_hi0");
    applyStimulus(1'b0, 2'b11);
    sampleOutput("glitch_lo");
    applyStimulus(1'b1, 2'b11);
    sampleOutput("glitch_hi1");

    // Streaming with a short reset pulse inside the low clock phase.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'(i));
      sampleOutput("stream");
    end
    @(negedge clk);
    en = 1'b1;
    a  = 2'b11;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_y", {28'd0, y}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, y_valid}, 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_y", {28'd0, y}, 32'h8);
    checkOutput("post_rst_valid", {31'd0, y_valid}, 32'd1);

    applyStimulus(1'b1, 2'b00);
    sampleOutput("post_rst_next");

    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
